// File: rtl/envelope_pkg.sv
// Shared types and widths for the ADSR envelope shaper.
// State codes are visible on state_out, so their encoding is fixed.
package envelope_pkg;

    localparam int ENV_W   = 16;
    localparam int LEVEL_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } env_state_e;

endpackage

// File: rtl/envelope_shaper_amp_scaler.sv
// Registered signed sample x unsigned level scaler, result = (amp * level) >>> 8.
// Latency 1 cycle from step_in; no backpressure, every strobe loads a new sample.
module amp_scaler
    import envelope_pkg::*;
(
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      step_in,
    input  logic [LEVEL_W-1:0]        amp_in,
    input  logic [LEVEL_W-1:0]        level_in,
    output logic [LEVEL_W-1:0]        amp_out,
    output logic                      valid_out
);

    logic signed [2*LEVEL_W:0] prod;
    logic signed [2*LEVEL_W:0] shifted;
    logic                      shift_unused;
    logic [LEVEL_W-1:0]        amp_q;
    logic                      valid_q;

    // Level is zero-extended so 0xFF stays a positive gain just under unity.
    assign prod         = $signed(amp_in) * $signed({1'b0, level_in});
    assign shifted      = prod >>> LEVEL_W;
    assign shift_unused = ^shifted[2*LEVEL_W:LEVEL_W];

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            amp_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= step_in;
            if (step_in) begin
                amp_q <= shifted[LEVEL_W-1:0];
            end
        end
    end

    assign amp_out   = amp_q;
    assign valid_out = valid_q;

endmodule

// File: rtl/envelope_shaper.sv
// ADSR envelope generator advancing once per sample strobe, scaling the oscillator sample by the level.
// Output latency 1 cycle after step_in; no backpressure, back-to-back strobes are all processed.
module envelope_shaper
    import envelope_pkg::*;
(
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               step_in,
    input  logic               gate_in,
    input  logic [LEVEL_W-1:0] amp_in,
    input  logic [LEVEL_W-1:0] attack_rate_in,
    input  logic [LEVEL_W-1:0] decay_rate_in,
    input  logic [LEVEL_W-1:0] release_rate_in,
    input  logic [LEVEL_W-1:0] sustain_level_in,
    output logic [LEVEL_W-1:0] amp_out,
    output logic               valid_out,
    output logic [LEVEL_W-1:0] env_out,
    output logic [2:0]         state_out,
    output logic               busy_out
);

    env_state_e         state_q, state_d;
    logic [ENV_W-1:0]   env_q, env_d;
    logic               armed_q;
    logic               step_en;
    logic [ENV_W-1:0]   target;
    logic [ENV_W:0]     sum_att;
    logic [ENV_W:0]     dif_dec;
    logic [ENV_W:0]     dif_rel;

    // armed_q stays low through the first edge after reset so a coincident strobe is dropped.
    assign step_en = step_in & armed_q;
    assign target  = {sustain_level_in, {(ENV_W-LEVEL_W){1'b0}}};
    assign sum_att = {1'b0, env_q} + {{(ENV_W-LEVEL_W+1){1'b0}}, attack_rate_in};
    assign dif_dec = {1'b0, env_q} - {{(ENV_W-LEVEL_W+1){1'b0}}, decay_rate_in};
    assign dif_rel = {1'b0, env_q} - {{(ENV_W-LEVEL_W+1){1'b0}}, release_rate_in};

    always_comb begin
        state_d = state_q;
        env_d   = env_q;
        case (state_q)
            ST_IDLE: begin
                env_d = '0;
                if (gate_in) state_d = ST_ATTACK;
            end
            ST_ATTACK: begin
                if (!gate_in) begin
                    state_d = ST_RELEASE;
                end else if (sum_att >= {1'b0, {ENV_W{1'b1}}} || attack_rate_in == '0) begin
                    env_d   = '1;
                    state_d = ST_DECAY;
                end else begin
                    env_d = sum_att[ENV_W-1:0];
                end
            end
            ST_DECAY: begin
                if (!gate_in) begin
                    state_d = ST_RELEASE;
                end else if ($signed(dif_dec) <= $signed({1'b0, target}) || decay_rate_in == '0) begin
                    env_d   = target;
                    state_d = ST_SUSTAIN;
                end else begin
                    env_d = dif_dec[ENV_W-1:0];
                end
            end
            ST_SUSTAIN: begin
                env_d = target;
                if (!gate_in) state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                // Retrigger resumes attack from the current level rather than from zero.
                if (gate_in) begin
                    state_d = ST_ATTACK;
                end else if ($signed(dif_rel) <= $signed({(ENV_W+1){1'b0}}) || release_rate_in == '0) begin
                    env_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    env_d = dif_rel[ENV_W-1:0];
                end
            end
            default: begin
                env_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= ST_IDLE;
            env_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            armed_q <= 1'b1;
            if (step_en) begin
                state_q <= state_d;
                env_q   <= env_d;
            end
        end
    end

    amp_scaler u_amp_scaler (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .step_in   (step_en),
        .amp_in    (amp_in),
        .level_in  (env_q[ENV_W-1:ENV_W-LEVEL_W]),
        .amp_out   (amp_out),
        .valid_out (valid_out)
    );

    assign env_out   = env_q[ENV_W-1:ENV_W-LEVEL_W];
    assign state_out = state_q;
    assign busy_out  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_envelope_shaper.sv
// Directed bench for envelope_shaper: integer envelope model plus a scoreboard of expected samples.
module tb_envelope_shaper;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic       step_in;
    logic       gate_in;
    logic [7:0] amp_in;
    logic [7:0] attack_rate_in, decay_rate_in, release_rate_in, sustain_level_in;
    logic [7:0] amp_out;
    logic       valid_out;
    logic [7:0] env_out;
    logic [2:0] state_out;
    logic       busy_out;

    int         total = 0;
    int         bad   = 0;
    int         m_env = 0;
    int         m_st  = 0;
    logic [7:0] sb_q[$];

    envelope_shaper dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .step_in          (step_in),
        .gate_in          (gate_in),
        .amp_in           (amp_in),
        .attack_rate_in   (attack_rate_in),
        .decay_rate_in    (decay_rate_in),
        .release_rate_in  (release_rate_in),
        .sustain_level_in (sustain_level_in),
        .amp_out          (amp_out),
        .valid_out        (valid_out),
        .env_out          (env_out),
        .state_out        (state_out),
        .busy_out         (busy_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input int obs, input int expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] exp_amp(input logic [7:0] a, input int env);
        int p;
        p = int'($signed(a)) * (env / 256);
        p = p >>> 8;
        return p[7:0];
    endfunction

    task automatic model_step();
        int t;
        case (m_st)
            0: begin
                m_env = 0;
                if (gate_in) m_st = 1;
            end
            1: begin
                if (!gate_in) m_st = 4;
                else begin
                    t = m_env + int'(attack_rate_in);
                    if (t >= 65535 || attack_rate_in == 0) begin m_env = 65535; m_st = 2; end
                    else m_env = t;
                end
            end
            2: begin
                if (!gate_in) m_st = 4;
                else begin
                    t = m_env - int'(decay_rate_in);
                    if (t <= int'(sustain_level_in) * 256 || decay_rate_in == 0) begin
                        m_env = int'(sustain_level_in) * 256;
                        m_st  = 3;
                    end else m_env = t;
                end
            end
            3: begin
                m_env = int'(sustain_level_in) * 256;
                if (!gate_in) m_st = 4;
            end
            default: begin
                if (gate_in) m_st = 1;
                else begin
                    t = m_env - int'(release_rate_in);
                    if (t <= 0 || release_rate_in == 0) begin m_env = 0; m_st = 0; end
                    else m_env = t;
                end
            end
        endcase
    endtask

    // One strobe: expected sample queued from the pre-update level, outputs checked 1 ns after the edge.
    task automatic step1();
        logic [7:0] want;
        @(negedge clk_in);
        step_in = 1'b1;
        sb_q.push_back(exp_amp(amp_in, m_env));
        model_step();
        @(posedge clk_in);
        #1;
        chk("valid", int'(valid_out), 1);
        if (valid_out && sb_q.size() > 0) begin
            want = sb_q.pop_front();
            chk("amp", int'(amp_out), int'(want));
        end
        chk("env_out", int'(env_out), m_env / 256);
        chk("state", int'(state_out), m_st);
        chk("busy", int'(busy_out), (m_st != 0) ? 1 : 0);
    endtask

    task automatic idle1();
        @(negedge clk_in);
        step_in = 1'b0;
        @(posedge clk_in);
        #1;
        chk("valid_idle", int'(valid_out), 0);
    endtask

    initial begin
        int n;
        rst_in = 1'b1; step_in = 1'b0; gate_in = 1'b0; amp_in = 8'h00;
        attack_rate_in = 8'h00; decay_rate_in = 8'h00; release_rate_in = 8'h00; sustain_level_in = 8'h00;
        #1 rst_in = 1'b0;
        #1;
        chk("rst_amp", int'(amp_out), 0);
        chk("rst_valid", int'(valid_out), 0);
        chk("rst_env", int'(env_out), 0);
        chk("rst_state", int'(state_out), 0);
        chk("rst_busy", int'(busy_out), 0);
        repeat (2) @(posedge clk_in);
        @(negedge clk_in) rst_in = 1'b1;
        repeat (2) @(posedge clk_in);
        #1;

        // Fast path with zero rates, plus signed corner levels.
        sustain_level_in = 8'h80; gate_in = 1'b1; amp_in = 8'h7F;
        step1(); chk("lvl0_pos", int'(amp_out), 0);
        step1(); chk("fast_decay_env", int'(env_out), 'hFF);
        amp_in = 8'h80;
        step1(); chk("fast_sustain_env", int'(env_out), 'h80);
        chk("lvl_ff_neg128", int'(amp_out), 'h80);
        amp_in = 8'h7F;
        step1(); chk("fast_amp_63", int'(amp_out), 63);
        sustain_level_in = 8'h01; amp_in = 8'hFF;
        step1();
        step1(); chk("lvl01_neg1", int'(amp_out), 'hFF);
        gate_in = 1'b0;
        step1(); chk("sus_to_rel", int'(state_out), 4);
        step1(); chk("rel0_to_idle", int'(state_out), 0);
        amp_in = 8'h80;
        step1(); chk("lvl0_neg", int'(amp_out), 0);
        idle1();

        // Full-length attack at rate 0xFF.
        attack_rate_in = 8'hFF; gate_in = 1'b1;
        step1();
        n = 0;
        for (int i = 0; i < 400 && state_out == 3'd1; i++) begin
            step1();
            n++;
        end
        chk("attack_len", n, 257);
        chk("attack_end_state", int'(state_out), 2);
        chk("attack_end_env", int'(dut.env_q), 'hFFFF);

        // Gate drop on the step that would saturate the attack.
        gate_in = 1'b0;
        step1(); step1();
        gate_in = 1'b1;
        step1();
        repeat (256) step1();
        gate_in = 1'b0;
        step1();
        chk("prio_state", int'(state_out), 4);
        chk("prio_env", int'(dut.env_q), 'hFF00);

        // Release from decay at 0xC000 and retrigger.
        release_rate_in = 8'h00;
        step1();
        attack_rate_in = 8'h00; sustain_level_in = 8'h00; gate_in = 1'b1;
        step1(); step1();
        decay_rate_in = 8'h7F;
        repeat (129) step1();
        chk("dec_env_q", int'(dut.env_q), 'hC000);
        chk("dec_env_out", int'(env_out), 'hC0);
        gate_in = 1'b0; release_rate_in = 8'h40;
        step1(); step1(); step1();
        chk("rel_env_q", int'(dut.env_q), 'hBF80);
        gate_in = 1'b1; attack_rate_in = 8'h7F;
        step1();
        chk("retrig_state", int'(state_out), 1);
        chk("retrig_env_q", int'(dut.env_q), 'hBF80);
        step1(); chk("retrig_env1", int'(env_out), 'hBF);
        step1(); chk("retrig_env2", int'(env_out), 'hC0);

        // Asynchronous reset in RELEASE, then a strobe coincident with release.
        gate_in = 1'b0; release_rate_in = 8'h01;
        step1(); step1();
        #2 rst_in = 1'b0;
        #1;
        chk("arst_amp", int'(amp_out), 0);
        chk("arst_valid", int'(valid_out), 0);
        chk("arst_env", int'(env_out), 0);
        chk("arst_state", int'(state_out), 0);
        chk("arst_busy", int'(busy_out), 0);
        m_env = 0; m_st = 0;
        sb_q.delete();
        @(negedge clk_in);
        rst_in = 1'b1; step_in = 1'b1; gate_in = 1'b1;
        @(posedge clk_in);
        #1;
        chk("ign_state", int'(state_out), 0);
        chk("ign_valid", int'(valid_out), 0);
        step1();
        idle1();
        chk("sb_drain", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/envelope_shaper.md
ENVELOPE_SHAPER -- requirements
Module: envelope_shaper

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk_in  input  1  system clock; all state updates on its rising edge.
REQ-003 rst_in  input  1  asynchronous, active-low reset.
REQ-004 step_in  input  1  one-cycle sample strobe, the same strobe that advances the upstream oscillator.
REQ-005 gate_in  input  1  note held (1) / released (0); sampled only in step_in cycles.
REQ-006 amp_in  input  8  signed two's-complement oscillator sample (upstream amp_out).
REQ-007 attack_rate_in, decay_rate_in, release_rate_in  input  8 each  unsigned increment/decrement per step; 0 means complete the phase in one step.
REQ-008 sustain_level_in  input  8  unsigned sustain level; sampled live.
REQ-009 amp_out  output  8  signed scaled sample.
REQ-010 valid_out  output  1  one-cycle pulse when amp_out updates.
REQ-011 env_out  output  8  current envelope level, equal to env_q[15:8].
REQ-012 state_out  output  3  current state code.
REQ-013 busy_out  output  1  high when state is not IDLE.

Function
REQ-014 The envelope accumulator env_q SHALL be 16-bit unsigned; all state and env_q changes SHALL occur only on clock edges where step_in=1.
REQ-015 States and codes: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4; codes 5-7 SHALL go to IDLE with env_q=0.
REQ-016 IDLE: env_q=0; gate_in=1 -> ATTACK with env_q unchanged.
REQ-017 ATTACK: gate_in=0 -> RELEASE with env_q unchanged; else env_q+attack_rate; if the 17-bit sum >= 0xFFFF or rate=0, env_q=0xFFFF and -> DECAY.
REQ-018 DECAY: gate_in=0 -> RELEASE; else target={sustain_level_in,8'h00}; if env_q-decay_rate <= target (signed 17-bit compare) or rate=0, env_q=target and -> SUSTAIN.
REQ-019 SUSTAIN: env_q={sustain_level_in,8'h00} every step; gate_in=0 -> RELEASE.
REQ-020 RELEASE: gate_in=1 -> ATTACK from the current env_q (retrigger, no reset to 0); else env_q-release_rate; if result <= 0 or rate=0, env_q=0 and -> IDLE.
REQ-021 gate_in transitions SHALL take priority over phase completion in the same step.
REQ-022 In a step_in cycle, the product register SHALL load (amp_in * {1'b0,env_q[15:8]}) >>> 8, using a 17-bit signed product, an arithmetic shift, and truncation to 8 bits, with env_q taken before that cycle's update.
REQ-023 amp_out SHALL be valid one cycle after step_in (latency 1), valid_out SHALL be high for exactly that cycle, and amp_out SHALL hold until the next update.
REQ-024 step_in on consecutive cycles SHALL each be processed; no strobe is dropped.

Reset
REQ-025 On rst_in=0, immediately and regardless of clk_in: state=IDLE, env_q=0, amp_out=0, valid_out=0, env_out=0, state_out=0, busy_out=0.
REQ-026 A step_in coinciding with reset release SHALL be ignored.

Structure
REQ-027 Package envelope_pkg SHALL hold the state enum (3-bit), ENV_W=16, and LEVEL_W=8.
REQ-028 Sub-module amp_scaler SHALL hold the registered signed 8x9 multiply and the >>>8 shift.

Verification
REQ-029 The bench SHALL cover the fast path: rates=0, sustain=0x80, gate=1, amp_in=0x7F; steps 1-3 -> ATTACK, DECAY (env_out=0xFF), SUSTAIN (env_out=0x80); the next amp_out=63.
REQ-030 The bench SHALL cover full-length attack: attack_rate=0xFF from IDLE; exactly 257 steps in ATTACK, then DECAY with env_q=0xFFFF.
REQ-031 The bench SHALL cover signed edges: env level 0xFF, amp_in=-128 -> amp_out=-128; level 0x01, amp_in=-1 -> -1; level 0, any amp_in -> 0.
REQ-032 The bench SHALL cover release and retrigger: gate drops in DECAY at env_out=0xC0, release_rate=0x40; gate rises after 2 steps -> ATTACK starting at env_q=0xBF80.
REQ-033 The bench SHALL cover reset: rst_in low mid-RELEASE between clock edges -> all outputs 0 and state_out=0 without a clock edge; the first step_in after release is ignored.
REQ-034 The bench SHALL cover gate priority: gate=0 on the step where ATTACK would saturate -> RELEASE, env_q unchanged.
